alu: RTL and testbench
======================

ALU -- requirements
Module: alu

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; all values below are for WIDTH=8.
REQ-002 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 rs_i  input  WIDTH  first operand (A).
REQ-005 rt_i  input  WIDTH  second operand (B).
REQ-006 opcode_i  input  3  operation select, encodings per REQ-010.
REQ-007 alu_result_o  output  WIDTH  registered result.
REQ-008 zero  output  1  registered flag: 1 when the registered result equals 0.
REQ-009 set_o  output  1  registered flag: 1 when A < B, signed two's complement.
REQ-009a ovf_o  output  1  registered signed-overflow flag; port always present (see REQ-020).

Function
REQ-010 Opcodes: 000 AND, 001 OR, 010 ADD (A+B), 011 NOT (~A, B ignored), 100 SUB (A-B), 101 SLT (result = {WIDTH-1 zeros, A<B signed}), 110 SLL (A shifted left by 1, LSB filled 0, B ignored), 111 XOR.
REQ-011 ADD/SUB are modulo 2^WIDTH; carry/borrow out is discarded.
REQ-012 Result computed combinationally from rs_i/rt_i/opcode_i and captured into alu_result_o on every rising clk_i edge; latency exactly 1 cycle, throughput 1 op/cycle, no handshake, no enable.
REQ-013 zero and set_o are captured in the same edge as alu_result_o and always describe that same operation.
REQ-014 set_o is computed for every opcode (not only SLT); zero is computed from the new result for every opcode.
REQ-015 Signed compare: A<B is determined from the sign of A-B corrected by overflow, so 0x80 < 0x7F is 1 and 0x7F < 0x80 is 0.
REQ-016 Equal operands: set_o = 0; SUB and XOR yield result 0 and zero = 1.
REQ-017 SLL: bit WIDTH-1 of A is discarded; 0xFF -> 0xFE.
REQ-018 No X propagation from unused operands: NOT and SLL results are independent of rt_i.

Reset
REQ-019 While rst_ni = 0, alu_result_o = 0, set_o = 0, ovf_o = 0, zero = 1 (consistent with result 0), asserted immediately without clock; first capture occurs on the first rising clk_i edge after rst_ni deasserts; reset mid-stream discards the in-flight result.

Configuration
REQ-020 Macro ALU_OVERFLOW_EN: when defined, ovf_o is registered with the result and is 1 for ADD when both operands share a sign differing from the result's sign, and for SUB when operand signs differ and the result's sign differs from A; 0 for all other opcodes. When not defined, ovf_o is tied to 0 and no overflow register is built; all other behaviour is identical.

Structure
REQ-021 Shared package alu_pkg holds the 3-bit opcode type/enumeration (OP_AND .. OP_XOR) and the default width constant; alu and its benches import it.
REQ-022 One sub-module alu_addsub (WIDTH-bit adder/subtractor producing sum, sign, and overflow) is shared by ADD, SUB, SLT and the set_o/ovf_o logic; all other logic lives in alu.

Verification
REQ-023 Reset: assert rst_ni=0 with clk_i stopped -> alu_result_o=0x00, zero=1, set_o=0, ovf_o=0 immediately.
REQ-024 Logic ops: A=0x55, B=0xAA, op 000 -> 0x00, zero=1; op 001 with A=0x0F, B=0xF0 -> 0xFF, zero=0; op 111 with A=B=0xFF -> 0x00, zero=1.
REQ-025 Arithmetic: A=0x05, B=0x02, op 010 -> 0x07; A=0xFD, B=0xFA, op 100 -> 0x03, set_o=0; with ALU_OVERFLOW_EN, A=0x7F, B=0x01, op 010 -> 0x80, ovf_o=1.
REQ-026 Unary: A=0xFE, op 011 -> 0x01; A=0xFF, op 110 -> 0xFE; both with rt_i driven to random values -> same results.
REQ-027 SLT: A=B=0x01, op 101 -> result 0x00, set_o=0; A=0x80, B=0x7F -> result 0x01, set_o=1.
REQ-028 Pipeline: change opcode/operands every cycle for 8 cycles -> each result appears exactly one edge later, in order; pulse rst_ni low mid-sequence -> outputs return to reset values without waiting for a clock edge.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU: default operand width and the opcode enumeration.
package alu_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_ADD = 3'b010,
        OP_NOT = 3'b011,
        OP_SUB = 3'b100,
        OP_SLT = 3'b101,
        OP_SLL = 3'b110,
        OP_XOR = 3'b111
    } opcode_e;

endpackage

// File: rtl/alu_addsub.sv
// WIDTH-bit modular adder/subtractor with sign and signed-overflow outputs.
// Subtraction is done as a + ~b + 1, so overflow is detected the same way for
// both: operands (after inversion) share a sign that the sum does not.
module alu_addsub
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             sub_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             sign_o,
    output logic             ovf_o
);

    logic [WIDTH-1:0] b_eff;

    // Two's complement add/subtract; carry out is intentionally dropped.
    always_comb begin
        b_eff  = sub_i ? ~b_i : b_i;
        sum_o  = a_i + b_eff + WIDTH'(sub_i);
        sign_o = sum_o[WIDTH-1];
        ovf_o  = (a_i[WIDTH-1] == b_eff[WIDTH-1]) && (sum_o[WIDTH-1] != a_i[WIDTH-1]);
    end

endmodule

// File: rtl/alu.sv
// Single-cycle registered ALU. Result, zero and set flags are captured together
// on every rising clock edge; there is no handshake and no enable.
// Optional feature macro: ALU_OVERFLOW_EN builds a registered signed-overflow
// flag for ADD/SUB; without it ovf_o is tied to 0.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] rs_i,
    input  logic [WIDTH-1:0] rt_i,
    input  logic [2:0]       opcode_i,
    output logic [WIDTH-1:0] alu_result_o,
    output logic             zero,
    output logic             set_o,
    output logic             ovf_o
);

    opcode_e          op;
    logic [WIDTH-1:0] add_sum;
    logic             add_sign;
    logic             add_ovf;
    logic [WIDTH-1:0] sub_sum;
    logic             sub_sign;
    logic             sub_ovf;
    logic             a_lt_b;
    logic             unused_add_flags;

    logic [WIDTH-1:0] result_d, result_q;
    logic             zero_d, zero_q;
    logic             set_d, set_q;

    assign op = opcode_e'(opcode_i);

    alu_addsub #(.WIDTH(WIDTH)) u_add (
        .a_i    (rs_i),
        .b_i    (rt_i),
        .sub_i  (1'b0),
        .sum_o  (add_sum),
        .sign_o (add_sign),
        .ovf_o  (add_ovf)
    );

    // The subtractor runs every cycle: it feeds SUB, SLT and the set flag.
    alu_addsub #(.WIDTH(WIDTH)) u_sub (
        .a_i    (rs_i),
        .b_i    (rt_i),
        .sub_i  (1'b1),
        .sum_o  (sub_sum),
        .sign_o (sub_sign),
        .ovf_o  (sub_ovf)
    );

    // Signed A < B: sign of A-B, flipped when the subtraction overflowed.
    assign a_lt_b = sub_sign ^ sub_ovf;

    // Next result and flags; unary ops never look at rt_i.
    always_comb begin
        result_d = '0;
        case (op)
            OP_AND:  result_d = rs_i & rt_i;
            OP_OR:   result_d = rs_i | rt_i;
            OP_ADD:  result_d = add_sum;
            OP_NOT:  result_d = ~rs_i;
            OP_SUB:  result_d = sub_sum;
            OP_SLT:  result_d = {{(WIDTH-1){1'b0}}, a_lt_b};
            OP_SLL:  result_d = {rs_i[WIDTH-2:0], 1'b0};
            OP_XOR:  result_d = rs_i ^ rt_i;
            default: result_d = '0;
        endcase
        zero_d = (result_d == '0);
        set_d  = a_lt_b;
    end

    // Result and flag registers; reset shows a zero result with zero flag set.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            result_q <= '0;
            zero_q   <= 1'b1;
            set_q    <= 1'b0;
        end else begin
            result_q <= result_d;
            zero_q   <= zero_d;
            set_q    <= set_d;
        end
    end

    assign alu_result_o = result_q;
    assign zero         = zero_q;
    assign set_o        = set_q;

`ifdef ALU_OVERFLOW_EN
    logic ovf_d, ovf_q;

    // Overflow only means something for ADD and SUB.
    always_comb begin
        ovf_d = 1'b0;
        if (op == OP_ADD) begin
            ovf_d = add_ovf;
        end else if (op == OP_SUB) begin
            ovf_d = sub_ovf;
        end
    end

    // Overflow flag captured alongside the result.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf_o            = ovf_q;
    assign unused_add_flags = add_sign;
`else
    assign ovf_o            = 1'b0;
    assign unused_add_flags = add_sign ^ add_ovf;
`endif

endmodule

// File: tb/tb_alu.sv
// Directed testbench for alu: reset with the clock stopped, each opcode with
// hand-computed results, unary ops with random rt_i, an 8-cycle back-to-back
// stream checked through an expected queue, and a mid-stream reset pulse.
module tb_alu;
    import alu_pkg::*;

    localparam int W = 8;
`ifdef ALU_OVERFLOW_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic         clk_i  = 1'b0;
    logic         clk_en = 1'b0;
    logic         rst_ni = 1'b1;
    logic [W-1:0] rs_i   = '0;
    logic [W-1:0] rt_i   = '0;
    logic [2:0]   opcode_i = 3'b000;
    logic [W-1:0] alu_result_o;
    logic         zero;
    logic         set_o;
    logic         ovf_o;

    always begin
        #5;
        if (clk_en) clk_i = ~clk_i;
    end

    alu #(.WIDTH(W)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .rs_i         (rs_i),
        .rt_i         (rt_i),
        .opcode_i     (opcode_i),
        .alu_result_o (alu_result_o),
        .zero         (zero),
        .set_o        (set_o),
        .ovf_o        (ovf_o)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_res"},  alu_result_o, 8'h00);
        check({tag, "_zero"}, W'(zero),  8'h01);
        check({tag, "_set"},  W'(set_o), 8'h00);
        check({tag, "_ovf"},  W'(ovf_o), 8'h00);
    endtask

    function automatic logic signed_lt(input logic [W-1:0] a, input logic [W-1:0] b);
        return $signed(a) < $signed(b);
    endfunction

    // Reference model packed as {ovf, set, zero, result}.
    function automatic logic [W+2:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [2:0] op);
        logic [W-1:0] r;
        logic         v;
        int           s;
        r = '0;
        v = 1'b0;
        case (op)
            3'b000: r = a & b;
            3'b001: r = a | b;
            3'b010: begin
                s = int'($signed(a)) + int'($signed(b));
                r = W'(s);
                v = (s > 127) || (s < -128);
            end
            3'b011: r = ~a;
            3'b100: begin
                s = int'($signed(a)) - int'($signed(b));
                r = W'(s);
                v = (s > 127) || (s < -128);
            end
            3'b101: r = signed_lt(a, b) ? 8'h01 : 8'h00;
            3'b110: r = a << 1;
            default: r = a ^ b;
        endcase
        return {v & OVF_ON, signed_lt(a, b), (r == 8'h00), r};
    endfunction

    // ---------------- driver ----------------
    task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2:0] op, input logic [W-1:0] er, input logic ez,
                         input logic es, input logic eo);
        rs_i = a;
        rt_i = b;
        opcode_i = op;
        @(posedge clk_i);
        #1;
        check({tag, "_res"},  alu_result_o, er);
        check({tag, "_zero"}, W'(zero),  W'(ez));
        check({tag, "_set"},  W'(set_o), W'(es));
        check({tag, "_ovf"},  W'(ovf_o), W'(eo & OVF_ON));
    endtask

    // ---------------- scoreboard for streaming ----------------
    logic [W+2:0] exp_q[$];

    initial begin
        logic [W-1:0] pa[8];
        logic [W-1:0] pb[8];
        logic [2:0]   pop[8];
        logic [W+2:0] e;
        logic [W-1:0] rb;

        // Reset with the clock stopped: outputs must settle without an edge.
        #2;
        rst_ni = 1'b0;
        #1;
        check_reset_outputs("rst_noclk");

        clk_en = 1'b1;
        rs_i = 8'h12; rt_i = 8'h34; opcode_i = OP_ADD;
        repeat (2) @(posedge clk_i);
        #1;
        check_reset_outputs("rst_held");
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Logic ops
        do_op("and",  8'h55, 8'hAA, OP_AND, 8'h00, 1'b1, 1'b0, 1'b0);
        do_op("or",   8'h0F, 8'hF0, OP_OR,  8'hFF, 1'b0, 1'b0, 1'b0);
        do_op("xor",  8'hFF, 8'hFF, OP_XOR, 8'h00, 1'b1, 1'b0, 1'b0);
        // Arithmetic
        do_op("add",  8'h05, 8'h02, OP_ADD, 8'h07, 1'b0, 1'b0, 1'b0);
        do_op("sub",  8'hFD, 8'hFA, OP_SUB, 8'h03, 1'b0, 1'b0, 1'b0);
        do_op("addv", 8'h7F, 8'h01, OP_ADD, 8'h80, 1'b0, 1'b0, 1'b1);
        do_op("addc", 8'hFF, 8'h01, OP_ADD, 8'h00, 1'b1, 1'b1, 1'b0);
        do_op("addn", 8'h80, 8'h80, OP_ADD, 8'h00, 1'b1, 1'b0, 1'b1);
        do_op("subv", 8'h80, 8'h01, OP_SUB, 8'h7F, 1'b0, 1'b1, 1'b1);
        do_op("subeq",8'h7F, 8'h7F, OP_SUB, 8'h00, 1'b1, 1'b0, 1'b0);
        // SLT and signed compare boundaries
        do_op("slteq",8'h01, 8'h01, OP_SLT, 8'h00, 1'b1, 1'b0, 1'b0);
        do_op("slt",  8'h80, 8'h7F, OP_SLT, 8'h01, 1'b0, 1'b1, 1'b0);
        do_op("sltr", 8'h7F, 8'h80, OP_SLT, 8'h00, 1'b1, 1'b0, 1'b0);
        // Unary ops with random rt_i
        for (int i = 0; i < 3; i++) begin
            rb = W'($urandom_range(0, 255));
            do_op("not", 8'hFE, rb, OP_NOT, 8'h01, 1'b0, signed_lt(8'hFE, rb), 1'b0);
            rb = W'($urandom_range(0, 255));
            do_op("sll", 8'hFF, rb, OP_SLL, 8'hFE, 1'b0, signed_lt(8'hFF, rb), 1'b0);
        end

        // Back-to-back stream: a new op every cycle, each result one edge later.
        pa  = '{8'h3C, 8'h81, 8'h7F, 8'hC3, 8'h00, 8'hF0, 8'h40, 8'h99};
        pb  = '{8'h0F, 8'h18, 8'h02, 8'h5A, 8'h01, 8'h7E, 8'hC0, 8'h99};
        pop = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111};
        for (int i = 0; i < 8; i++) begin
            rs_i = pa[i];
            rt_i = pb[i];
            opcode_i = pop[i];
            exp_q.push_back(model(pa[i], pb[i], pop[i]));
            @(posedge clk_i);
            #1;
            e = exp_q.pop_front();
            check($sformatf("pipe%0d_res", i),  alu_result_o, e[W-1:0]);
            check($sformatf("pipe%0d_zero", i), W'(zero),  W'(e[W]));
            check($sformatf("pipe%0d_set", i),  W'(set_o), W'(e[W+1]));
            check($sformatf("pipe%0d_ovf", i),  W'(ovf_o), W'(e[W+2]));
        end

        // Mid-stream reset: the in-flight op is dropped, outputs clear at once.
        rs_i = 8'h05; rt_i = 8'h02; opcode_i = OP_ADD;
        @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        @(posedge clk_i);
        #1;
        check_reset_outputs("rst_mid_edge");
        @(negedge clk_i);
        rst_ni = 1'b1;
        do_op("post_rst", 8'h10, 8'h03, OP_SUB, 8'h0D, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
